fetch_sequencer: RTL and testbench

- Multi-cycle instruction-fetch controller for the 16-bit CPU.
- Owns the program counter and fetches from instruction memory with a request/ready handshake.
- Presents each fetched word to decode with a valid/accept handshake.
- On accept, selects the next PC: halt, jump, taken branch or sequential.

---
 rtl/fetch_sequencer_pkg.sv | 35 +++
 rtl/fetch_sequencer_pc_register.sv | 24 ++
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_fetch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: widths, fetch state encoding and next-PC selection.
package fetch_sequencer_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int J_TARGET_BITS  = 12;
    localparam int BR_OFFSET_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    // Jump keeps the page bits of the current PC; branch is relative to PC+1.
    function automatic logic [WORD_SIZE-1:0] f_redirect_pc(
        input logic [WORD_SIZE-1:0]      pc,
        input logic                      jump,
        input logic [J_TARGET_BITS-1:0]  jump_target,
        input logic                      branch_taken,
        input logic [BR_OFFSET_BITS-1:0] branch_offset
    );
        logic [WORD_SIZE-1:0]        pc_inc;
        logic signed [WORD_SIZE-1:0] off_ext;
        pc_inc  = pc + WORD_SIZE'(1);
        off_ext = {{(WORD_SIZE-BR_OFFSET_BITS){branch_offset[BR_OFFSET_BITS-1]}}, branch_offset};
        if (jump) begin
            return {pc[WORD_SIZE-1:J_TARGET_BITS], jump_target};
        end else if (branch_taken) begin
            return pc_inc + off_ext;
        end
        return pc_inc;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// Program counter storage: asynchronous clear to 0, loads the next PC when enabled.
module pc_register
    import fetch_sequencer_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [WORD_SIZE-1:0] i_next_pc,
    output logic [WORD_SIZE-1:0] o_pc
);

    logic [WORD_SIZE-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: request/ready to memory, valid/accept to decode, PC redirect.
// Define FETCH_INST_COUNT_EN to add the num_inst accepted-instruction counter port.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    output logic                      mem_req,
    output logic [WORD_SIZE-1:0]      mem_addr,
    input  logic                      mem_ready,
    input  logic [WORD_SIZE-1:0]      mem_data,
    output logic                      inst_valid,
    output logic [WORD_SIZE-1:0]      inst_data,
    output logic [WORD_SIZE-1:0]      inst_pc,
    input  logic                      inst_accept,
    input  logic                      jump,
    input  logic [J_TARGET_BITS-1:0]  jump_target,
    input  logic                      branch_taken,
    input  logic [BR_OFFSET_BITS-1:0] branch_offset,
    input  logic                      halt,
    output logic                      halted
`ifdef FETCH_INST_COUNT_EN
    ,
    output logic [WORD_SIZE-1:0]      num_inst
`endif
);

    fetch_state_t         r_state;
    logic                 r_mem_req;
    logic                 r_inst_valid;
    logic [WORD_SIZE-1:0] r_inst_data;
    logic [WORD_SIZE-1:0] r_inst_pc;
    logic                 r_halted;

    logic                 w_accept;
    logic                 w_pc_load;
    logic [WORD_SIZE-1:0] w_pc;
    logic [WORD_SIZE-1:0] w_next_pc;

    // Decode handshake and redirect fields only matter while an instruction is held.
    assign w_accept  = (r_state == ST_HOLD) && inst_accept;
    assign w_pc_load = w_accept && !halt;
    assign w_next_pc = f_redirect_pc(w_pc, jump, jump_target, branch_taken, branch_offset);

    pc_register u_pc_register (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_load    (w_pc_load),
        .i_next_pc (w_next_pc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_REQ;
                    r_mem_req <= 1'b1;
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        r_inst_data  <= mem_data;
                        r_inst_pc    <= w_pc;
                        r_inst_valid <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (inst_accept) begin
                        r_inst_valid <= 1'b0;
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALTED;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = w_pc;
    assign inst_valid = r_inst_valid;
    assign inst_data  = r_inst_data;
    assign inst_pc    = r_inst_pc;
    assign halted     = r_halted;

`ifdef FETCH_INST_COUNT_EN
    logic [WORD_SIZE-1:0] r_num_inst;

    // Counts every accepted instruction, the halting one included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_inst <= '0;
        end else if (w_accept) begin
            r_num_inst <= r_num_inst + WORD_SIZE'(1);
        end
    end

    assign num_inst = r_num_inst;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, hand sequences and random traffic vs a model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_accept = 1'b0;
    logic        jump = 1'b0;
    logic [11:0] jump_target = 12'h0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_offset = 8'h0;
    logic        halt = 1'b0;
    logic        halted;
`ifdef FETCH_INST_COUNT_EN
    logic [15:0] num_inst;
`endif

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_accept   (inst_accept),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .halt          (halt),
        .halted        (halted)
`ifdef FETCH_INST_COUNT_EN
        ,
        .num_inst      (num_inst)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference: what the sequencer should be showing right now.
    bit m_started, m_req, m_valid, m_halted;
    int m_pc, m_data, m_ipc, m_cnt;

    typedef struct {
        int          start;
        bit          j;
        bit          b;
        bit          h;
        logic [11:0] jt;
        logic [7:0]  bo;
        int          exp_pc;
        bit          exp_halt;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_req = 0; m_valid = 0; m_halted = 0;
        m_pc = 0; m_data = 0; m_ipc = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (m_halted) return;
        if (!m_started) begin
            m_started = 1;
            m_req = 1;
        end else if (m_req) begin
            if (mem_ready) begin
                m_req   = 0;
                m_valid = 1;
                m_data  = int'(mem_data);
                m_ipc   = m_pc;
            end
        end else if (m_valid && inst_accept) begin
            m_valid = 0;
            m_cnt++;
            if (halt) begin
                m_halted = 1;
            end else begin
                m_req = 1;
                if (jump)
                    m_pc = (m_pc & 'hF000) | int'(jump_target);
                else if (branch_taken)
                    m_pc = (m_pc + 1 + int'($signed(branch_offset))) & 'hFFFF;
                else
                    m_pc = (m_pc + 1) & 'hFFFF;
            end
        end
    endtask

    task automatic check_all();
        check("mem_req", mem_req, m_req);
        check("mem_addr", mem_addr, m_pc);
        check("inst_valid", inst_valid, m_valid);
        check("inst_data", inst_data, m_data);
        check("inst_pc", inst_pc, m_ipc);
        check("halted", halted, m_halted);
`ifdef FETCH_INST_COUNT_EN
        check("num_inst", num_inst, m_cnt & 'hFFFF);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        mem_ready = 0; mem_data = 16'h0; inst_accept = 0; jump = 0;
        branch_taken = 0; halt = 0; jump_target = 12'h0; branch_offset = 8'h0;
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_halted", halted, 0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    task automatic accept_with(input bit j, input bit b, input bit h, input logic [11:0] jt, input logic [7:0] bo);
        int guard = 0;
        while (!m_valid && guard < 8) begin
            mem_ready     = 1'b1;
            mem_data      = 16'($urandom);
            inst_accept   = 1'($urandom);
            jump          = 1'($urandom);
            branch_taken  = 1'($urandom);
            halt          = 1'($urandom);
            jump_target   = 12'($urandom);
            branch_offset = 8'($urandom);
            tick();
            guard++;
        end
        check("accept_wait", inst_valid, 1);
        mem_ready     = 1'($urandom);
        mem_data      = 16'($urandom);
        inst_accept   = 1'b1;
        jump          = j;
        branch_taken  = b;
        halt          = h;
        jump_target   = jt;
        branch_offset = bo;
        tick();
        clear_inputs();
    endtask

    task automatic goto_pc(input int target);
        for (int s = 0; s < 700 && m_pc != target; s++) begin
            int diff;
            diff = (target - m_pc - 1) & 'hFFFF;
            if (diff >= 'h8000) diff -= 'h10000;
            if ((target & 'hF000) == (m_pc & 'hF000)) begin
                accept_with(1'b1, 1'b0, 1'b0, 12'(target), 8'h00);
            end else begin
                if (diff > 127) diff = 127;
                if (diff < -128) diff = -128;
                accept_with(1'b0, 1'b1, 1'b0, 12'h000, 8'(diff));
            end
        end
        check("goto_pc", mem_addr, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{'h3005, 1, 0, 0, 12'hABC, 8'h00, 'h3ABC, 0};
        tbl[1] = '{'h0010, 0, 1, 0, 12'h000, 8'hFC, 'h000D, 0};
        tbl[2] = '{'h0010, 1, 1, 0, 12'h020, 8'hFC, 'h0020, 0};
        tbl[3] = '{'hFFFF, 0, 0, 0, 12'h000, 8'h00, 'h0000, 0};
        tbl[4] = '{'h0042, 1, 0, 1, 12'h777, 8'h00, 'h0042, 1};
        tbl[5] = '{'h7FFF, 0, 1, 0, 12'h000, 8'h7F, 'h807F, 0};
        tbl[6] = '{'h0000, 0, 1, 0, 12'h000, 8'h80, 'hFF81, 0};
        tbl[7] = '{'h1234, 0, 1, 1, 12'h000, 8'h10, 'h1234, 1};
        tbl[8] = '{'hF0FF, 1, 0, 0, 12'hFFF, 8'h00, 'hFFFF, 0};
        tbl[9] = '{'h0005, 0, 1, 0, 12'h000, 8'h00, 'h0006, 0};

        model_reset();

        // Back-to-back fetch with immediate ready and accept.
        do_reset();
        mem_ready = 1; inst_accept = 1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("seq_valid", inst_valid, k % 2);
            if (k % 2 == 0) check("seq_addr", mem_addr, k / 2);
        end
`ifdef FETCH_INST_COUNT_EN
        check("seq_count", num_inst, 3);
`endif

        // Memory stall in REQ, then decode stall in HOLD.
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_req", mem_req, 1);
            check("stall_addr", mem_addr, 0);
            check("stall_valid", inst_valid, 0);
        end
        mem_ready = 1; mem_data = 16'hBEEF;
        tick();
        check("stall_got_valid", inst_valid, 1);
        check("stall_got_data", inst_data, 16'hBEEF);
        mem_ready = 1; mem_data = 16'h1111; jump = 1; jump_target = 12'h555;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_valid", inst_valid, 1);
            check("hold_data", inst_data, 16'hBEEF);
            check("hold_req", mem_req, 0);
        end
        clear_inputs();
        inst_accept = 1;
        tick();
        check("hold_release_valid", inst_valid, 0);
        check("hold_release_addr", mem_addr, 1);
        clear_inputs();

        // Redirect table.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            goto_pc(tbl[i].start);
            accept_with(tbl[i].j, tbl[i].b, tbl[i].h, tbl[i].jt, tbl[i].bo);
            check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_pc);
            check($sformatf("tbl%0d_halted", i), halted, tbl[i].exp_halt);
            check($sformatf("tbl%0d_req", i), mem_req, !tbl[i].exp_halt);
            if (tbl[i].exp_halt) begin
                for (int k = 0; k < 3; k++) begin
                    mem_ready = 1; inst_accept = 1; jump = 1;
                    tick();
                    check("halt_req", mem_req, 0);
                    check("halt_addr", mem_addr, tbl[i].exp_pc);
                end
                clear_inputs();
            end
        end

        // Reset while a request is outstanding at a nonzero PC.
        do_reset();
        goto_pc('h0123);
        check("mid_req", mem_req, 1);
        do_reset();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            mem_ready     = ($urandom_range(0, 99) < 50);
            mem_data      = 16'($urandom);
            inst_accept   = ($urandom_range(0, 99) < 60);
            jump          = ($urandom_range(0, 99) < 10);
            branch_taken  = ($urandom_range(0, 99) < 20);
            halt          = ($urandom_range(0, 99) < 3);
            jump_target   = 12'($urandom);
            branch_offset = 8'($urandom);
            tick();
            if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0)
                do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
